// File: rtl/bk_adder_checker_pkg.sv
// Shared types and defaults for the Brent-Kung adder response checker.
package bk_pkg;

  localparam int BK_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2
  } bk_chk_state_t;

endpackage

// File: rtl/bk_adder_checker_if.sv
// Operand-offer channel feeding the adder checker.
interface bk_adder_checker_if
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH_DEFAULT
) ();
  // An operand set transfers on a rising edge where stim_valid && stim_ready.
  // The source holds stim_valid and the operands stable until that edge.
  logic             stim_valid;
  logic             stim_ready;
  logic [WIDTH-1:0] stim_a;
  logic [WIDTH-1:0] stim_b;
  logic             stim_cin;

  modport master (output stim_valid, stim_a, stim_b, stim_cin, input stim_ready);
  modport slave  (input stim_valid, stim_a, stim_b, stim_cin, output stim_ready);
endinterface

// File: rtl/bk_adder_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module bk_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/bk_adder_checker.sv
// Clocked response checker for the Brent-Kung adder: hold operands, wait, compare, count.
// Optional first-mismatch capture ports are built when BK_CHK_ERRCAP_EN is defined.
module bk_adder_checker
  import bk_pkg::*;
#(
  parameter int WIDTH      = BK_WIDTH_DEFAULT,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bk_adder_checker_if.slave  stim,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               op_cin,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  input  logic               clear,
  output logic               res_valid,
  output logic               res_ok,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               busy,
  output bk_chk_state_t      dbg_state
`ifdef BK_CHK_ERRCAP_EN
  ,
  output logic               err_valid,
  output logic [WIDTH-1:0]   err_a,
  output logic [WIDTH-1:0]   err_b,
  output logic               err_cin,
  output logic [WIDTH-1:0]   err_sum,
  output logic               err_cout
`endif
);
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("SETTLE_CYC must be within 1..255");
  end

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  bk_chk_state_t    r_state;
  bk_chk_state_t    w_next_state;
  logic [7:0]       r_settle_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_cin;
  logic             r_res_valid;
  logic             r_res_ok;
  logic             w_accept;
  logic             w_compare;
  logic             w_match;
  logic [WIDTH:0]   w_expected;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_compare    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stim.stim_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 8'd0) w_next_state = ST_COMPARE;
      end
      ST_COMPARE: begin
        w_compare    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reference sum is formed from the held operands, so it is stable for the whole settle window.
  assign w_expected = {1'b0, r_op_a} + {1'b0, r_op_b} + {{WIDTH{1'b0}}, r_op_cin};
  assign w_match    = ({dut_cout, dut_sum} == w_expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 8'd0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_cin     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_ok     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_res_valid <= w_compare;
      if (w_accept) begin
        r_op_a       <= stim.stim_a;
        r_op_b       <= stim.stim_b;
        r_op_cin     <= stim.stim_cin;
        r_settle_cnt <= SETTLE_INIT;
      end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 8'd0)) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end
      if (w_compare) r_res_ok <= w_match;
    end
  end

  bk_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_compare && w_match),
    .clr   (clear),
    .cnt   (pass_cnt)
  );

  bk_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_compare && !w_match),
    .clr   (clear),
    .cnt   (fail_cnt)
  );

`ifdef BK_CHK_ERRCAP_EN
  logic             r_err_valid;
  logic [WIDTH-1:0] r_err_a;
  logic [WIDTH-1:0] r_err_b;
  logic             r_err_cin;
  logic [WIDTH-1:0] r_err_sum;
  logic             r_err_cout;

  // Only the first mismatch since reset/clear is kept; clear beats a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_a     <= '0;
      r_err_b     <= '0;
      r_err_cin   <= 1'b0;
      r_err_sum   <= '0;
      r_err_cout  <= 1'b0;
    end else if (clear) begin
      r_err_valid <= 1'b0;
      r_err_a     <= '0;
      r_err_b     <= '0;
      r_err_cin   <= 1'b0;
      r_err_sum   <= '0;
      r_err_cout  <= 1'b0;
    end else if (w_compare && !w_match && !r_err_valid) begin
      r_err_valid <= 1'b1;
      r_err_a     <= r_op_a;
      r_err_b     <= r_op_b;
      r_err_cin   <= r_op_cin;
      r_err_sum   <= dut_sum;
      r_err_cout  <= dut_cout;
    end
  end

  assign err_valid = r_err_valid;
  assign err_a     = r_err_a;
  assign err_b     = r_err_b;
  assign err_cin   = r_err_cin;
  assign err_sum   = r_err_sum;
  assign err_cout  = r_err_cout;
`endif

  assign stim.stim_ready = (r_state == ST_IDLE);
  assign busy            = (r_state == ST_SETTLE) || (r_state == ST_COMPARE);
  assign op_a            = r_op_a;
  assign op_b            = r_op_b;
  assign op_cin          = r_op_cin;
  assign res_valid       = r_res_valid;
  assign res_ok          = r_res_ok;
  assign dbg_state       = r_state;
endmodule

// File: tb/tb_bk_adder_checker.sv
// Bench for bk_adder_checker: faultable adder model, queue scoreboard, directed and random checks.
module tb_bk_adder_checker;
  import bk_pkg::*;

  localparam int W     = 32;
  localparam int S     = 3;
  localparam int CW    = 4;
  localparam int QW    = 99;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  op_a, op_b;
  logic          op_cin;
  logic [W-1:0]  dut_sum;
  logic          dut_cout;
  logic          clear;
  logic          res_valid, res_ok;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic          busy;
  bk_chk_state_t dbg_state;
`ifdef BK_CHK_ERRCAP_EN
  logic          err_valid, err_cin, err_cout;
  logic [W-1:0]  err_a, err_b, err_sum;
  logic          m_err_valid, m_err_cin;
  logic [W-1:0]  m_err_a, m_err_b;
  logic [W:0]    m_err_resp;
`endif

  bk_adder_checker_if #(.WIDTH(W)) u_if ();

  bk_adder_checker #(.WIDTH(W), .SETTLE_CYC(S), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stim      (u_if.slave),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .dut_sum   (dut_sum),
    .dut_cout  (dut_cout),
    .clear     (clear),
    .res_valid (res_valid),
    .res_ok    (res_ok),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef BK_CHK_ERRCAP_EN
    ,
    .err_valid (err_valid),
    .err_a     (err_a),
    .err_b     (err_b),
    .err_cin   (err_cin),
    .err_sum   (err_sum),
    .err_cout  (err_cout)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- adder model with injectable output fault ----------------
  logic [W:0] fault_next, fault_live;
  assign {dut_cout, dut_sum} = ({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin}) ^ fault_live;

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_pass, m_fail;
  logic          clr_at_edge;
  int            acc_n = 0;
  time           acc_t;
  logic [W-1:0]  acc_a, acc_b;
  logic          acc_cin;
  logic [W:0]    sb_full, sb_resp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record each accepted operand set with the response the adder model will give it.
  always @(posedge clk) begin
    clr_at_edge <= clear;
    if (rst_n && u_if.stim_valid && u_if.stim_ready) begin
      fault_live <= fault_next;
      acc_a      <= u_if.stim_a;
      acc_b      <= u_if.stim_b;
      acc_cin    <= u_if.stim_cin;
      acc_n      <= acc_n + 1;
      acc_t      <= $time;
      sb_full = {1'b0, u_if.stim_a} + {1'b0, u_if.stim_b} + {{W{1'b0}}, u_if.stim_cin};
      sb_resp = sb_full ^ fault_next;
      exp_q.push_back({(sb_resp == sb_full), u_if.stim_a, u_if.stim_b, u_if.stim_cin, sb_resp});
    end
  end

  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (rst_n) begin
      if (clr_at_edge) begin
        m_pass = 0;
        m_fail = 0;
`ifdef BK_CHK_ERRCAP_EN
        m_err_valid = 1'b0; m_err_a = '0; m_err_b = '0; m_err_cin = 1'b0; m_err_resp = '0;
`endif
      end
      if (res_valid) begin
        check("q_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_ok", res_ok, e[98]);
          if (!clr_at_edge) begin
            if (e[98]) begin
              if (m_pass < MAXC) m_pass++;
            end else begin
              if (m_fail < MAXC) m_fail++;
`ifdef BK_CHK_ERRCAP_EN
              if (!m_err_valid) begin
                m_err_valid = 1'b1; m_err_a = e[97:66]; m_err_b = e[65:34];
                m_err_cin = e[33]; m_err_resp = e[32:0];
              end
`endif
            end
          end
        end
      end
      if (res_valid || clr_at_edge) begin
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
`ifdef BK_CHK_ERRCAP_EN
        check("err_valid", err_valid, m_err_valid);
        check("err_a", err_a, m_err_a);
        check("err_b", err_b, m_err_b);
        check("err_cin", err_cin, m_err_cin);
        check("err_resp", {err_cout, err_sum}, m_err_resp);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] mask, input bit clr_cmp);
    int wait_n = 0;
    @(negedge clk);
    u_if.stim_valid = 1'b1;
    u_if.stim_a     = a;
    u_if.stim_b     = b;
    u_if.stim_cin   = cin;
    fault_next      = mask;
    while (!u_if.stim_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!u_if.stim_ready) check("accept_timeout", u_if.stim_ready, 1);
    @(negedge clk);
    u_if.stim_valid = 1'b0;
    u_if.stim_a     = $urandom;
    u_if.stim_b     = $urandom;
    u_if.stim_cin   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= S + 1; k++) begin
      if (k > 1) @(negedge clk);
      check("busy", busy, 1);
      check("ready_busy", u_if.stim_ready, 0);
      check("op_a_hold", op_a, a);
      check("op_b_hold", op_b, b);
      check("op_cin_hold", op_cin, cin);
      check("res_valid_early", res_valid, 0);
      if (k == S + 1 && clr_cmp) clear = 1'b1;
    end
    @(negedge clk);
    clear = 1'b0;
    check("res_valid", res_valid, 1);
    check("ready_after", u_if.stim_ready, 1);
    check("busy_after", busy, 0);
    @(negedge clk);
    check("res_valid_pulse", res_valid, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_pass = 0;
    m_fail = 0;
`ifdef BK_CHK_ERRCAP_EN
    m_err_valid = 1'b0; m_err_a = '0; m_err_b = '0; m_err_cin = 1'b0; m_err_resp = '0;
`endif
  endtask

  task automatic check_reset_values();
    check("rst_ready", u_if.stim_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_cin", op_cin, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ok", res_ok, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
`ifdef BK_CHK_ERRCAP_EN
    check("rst_err_valid", err_valid, 0);
    check("rst_err_resp", {err_cout, err_sum, err_a, err_b, err_cin}, 0);
`endif
  endtask

  function automatic logic [W:0] rand_mask();
    if ($urandom_range(0, 3) == 0) return (W + 1)'(1) << $urandom_range(0, W);
    return '0;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    clear           = 1'b0;
    u_if.stim_valid = 1'b0;
    u_if.stim_a     = '0;
    u_if.stim_b     = '0;
    u_if.stim_cin   = 1'b0;
    fault_next      = '0;
    fault_live      = '0;
    clr_at_edge     = 1'b0;
    apply_reset();
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'h89028902, 32'h11111111, 1'b1, '0, 1'b0);
    check("tp1_pass", pass_cnt, 1);
    run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, '0, 1'b0);
    run_txn(32'h0000FFFF, 32'h00001110, 1'b0, 33'h1, 1'b0);
    check("tp3_fail", fail_cnt, 1);
`ifdef BK_CHK_ERRCAP_EN
    check("tp3_err_sum", err_sum, 32'h0001110E);
`endif
    run_txn(32'h12345678, 32'h0F0F0F0F, 1'b0, 33'h100000000, 1'b0);

    // Saturation: more passes than the counter can hold.
    for (int i = 0; i < MAXC + 3; i++) run_txn($urandom, $urandom, 1'($urandom_range(0, 1)), '0, 1'b0);
    check("sat_pass", pass_cnt, MAXC);

    run_txn($urandom, $urandom, 1'b1, '0, 1'b1);
    check("clr_cmp_pass", pass_cnt, 0);
    run_txn(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 33'h4, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("idle_clr_fail", fail_cnt, 0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      run_txn(ra, rb, 1'($urandom_range(0, 1)), rand_mask(), ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of SETTLE aborts the comparison.
    @(negedge clk);
    u_if.stim_valid = 1'b1;
    u_if.stim_a     = $urandom;
    u_if.stim_b     = $urandom;
    fault_next      = '0;
    @(negedge clk);
    u_if.stim_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    #2;
    apply_reset();
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      check("no_res_after_rst", res_valid, 0);
    end

    // Back-to-back: stim_valid held high throughout.
    begin
      int  last_n, seen;
      time t_prev;
      last_n          = acc_n;
      seen            = 0;
      t_prev          = 0;
      u_if.stim_a     = $urandom;
      u_if.stim_b     = $urandom;
      u_if.stim_cin   = 1'($urandom_range(0, 1));
      fault_next      = rand_mask();
      u_if.stim_valid = 1'b1;
      for (int c = 0; c < 100 && seen < 5; c++) begin
        @(negedge clk);
        if (acc_n != last_n) begin
          if (seen > 0) check("b2b_spacing", acc_t - t_prev, (S + 2) * 10);
          t_prev        = acc_t;
          last_n        = acc_n;
          seen++;
          u_if.stim_a   = $urandom;
          u_if.stim_b   = $urandom;
          u_if.stim_cin = 1'($urandom_range(0, 1));
          fault_next    = rand_mask();
        end else if (busy) begin
          check("b2b_op_a", op_a, acc_a);
          check("b2b_op_b", op_b, acc_b);
          check("b2b_op_cin", op_cin, acc_cin);
        end
      end
      if (seen < 5) check("b2b_accepts", seen, 5);
      u_if.stim_valid = 1'b0;
      repeat (S + 4) @(negedge clk);
    end

    check("q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bk_adder_checker.md
# bk_adder_checker

Self-checking response receiver for the 32-bit Brent-Kung adder. It accepts one operand set per handshake and drives it to the adder. It waits a fixed settle interval for the carry tree to resolve, then samples `sum`/`carryOut` and compares them against a behavioural `A+B+cin`. It keeps saturating pass/fail counts and sits on the adder's output side in the FPGA/emulation harness, replacing bench-only timed `#` delays with clocked checking.

## Interface
Parameters:
- `WIDTH`, 32: operand and sum width.
- `SETTLE_CYC`, 3: clock cycles operands are held before sampling; legal range 1 to 255.
- `CNT_W`, 16: width of the pass and fail counters.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stim_valid`  in  1: operand set offered.
- `stim_ready`  out  1: checker can accept; high only in IDLE.
- `stim_a`, `stim_b`  in  WIDTH: operands.
- `stim_cin`  in  1: carry-in.
- `op_a`, `op_b`  out  WIDTH: registered operands driven to the adder's `inputA`/`inputB`.
- `op_cin`  out  1: registered carry-in driven to the adder's `carryin`.
- `dut_sum`  in  WIDTH: adder `sum`.
- `dut_cout`  in  1: adder `carryOut`.
- `clear`  in  1: synchronous clear of counters and error capture.
- `res_valid`  out  1: one-cycle pulse when a comparison completes.
- `res_ok`  out  1: result of the last comparison; 1 means match.
- `pass_cnt`, `fail_cnt`  out  CNT_W: saturating counts of matches and mismatches.
- `busy`  out  1: high in SETTLE and COMPARE.

## Operation
- FSM has three states: IDLE, SETTLE, COMPARE.
- IDLE:
  - `stim_ready`=1.
  - On `stim_valid`&&`stim_ready`, load `op_*` from `stim_*`, load the settle counter with SETTLE_CYC-1, and go to SETTLE.
- SETTLE:
  - `op_*` are held stable.
  - The counter decrements each cycle.
  - When the counter reaches 0, go to COMPARE.
- COMPARE, lasting one cycle:
  - Form `expected = {1'b0,op_a} + {1'b0,op_b} + op_cin`, WIDTH+1 bits wide.
  - Set `match = ({dut_cout,dut_sum} == expected)`.
  - Register `res_ok=match` and `res_valid=1`.
  - Increment `pass_cnt` on a match or `fail_cnt` otherwise, then go to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `clear`:
  - Zeroes both counters and the error capture at the next edge.
  - Takes priority over a same-cycle increment; that comparison is lost from the counts, but `res_valid` and `res_ok` still report it.
  - Does not change FSM state or `op_*`.
- `stim_valid` while not IDLE is ignored; the stimulus source must hold it until `stim_ready` is high.
- Reset while in SETTLE or COMPARE aborts the comparison without a `res_valid` pulse.

## Timing
- Accept at edge E0. `op_*` are valid from E0 onward.
- SETTLE occupies SETTLE_CYC cycles; COMPARE occupies edge E0+SETTLE_CYC to edge E0+SETTLE_CYC+1.
- `res_valid` is high for exactly one cycle after edge E0+SETTLE_CYC+1; `stim_ready` is high in that same cycle.
- Back-to-back throughput is one check per SETTLE_CYC+2 cycles.
- Reset values:
  - state IDLE
  - `stim_ready`=1, `busy`=0
  - `op_a`=0, `op_b`=0, `op_cin`=0
  - `res_valid`=0, `res_ok`=0
  - `pass_cnt`=0, `fail_cnt`=0
  - all `err_*`=0

## Configuration
- `BK_CHK_ERRCAP_EN` defined:
  - Adds outputs `err_valid` (1), `err_a` and `err_b` (WIDTH), `err_cin` (1), `err_sum` (WIDTH), and `err_cout` (1).
  - On the first mismatch after reset or `clear`, these latch the operands and the DUT response, and set `err_valid`=1.
  - Later mismatches do not overwrite them.
- `BK_CHK_ERRCAP_EN` undefined: these ports and registers do not exist; counters only.

## Structure
- Package `bk_pkg`:
  - FSM state enum `bk_chk_state_t` (IDLE, SETTLE, COMPARE).
  - `BK_WIDTH_DEFAULT`=32.
- Sub-module `bk_sat_counter` (parameter CNT_W; ports `inc`, `clr`, `cnt`), instantiated twice for pass and fail.

## Test plan
- A=0x89028902, B=0x11111111, cin=1, correct adder → after SETTLE_CYC+1 edges, `res_valid` pulses; `res_ok`=1, sum=0x9A139A14, cout=0, `pass_cnt`=1.
- A=B=0xFFFFFFFF, cin=1 → expected sum=0xFFFFFFFF, cout=1, `res_ok`=1.
- A=0xFFFF, B=0x1110, cin=0 with a DUT model forcing sum bit 0 wrong (0x1110E) → `res_ok`=0, `fail_cnt`=1. With the macro, `err_valid`=1, `err_sum`=0x1110E, and `err_a`/`err_b` hold the operands.
- Reset asserted in SETTLE → immediately IDLE and `stim_ready`=1; counters 0; no `res_valid`.
- CNT_W=2, five passing checks → `pass_cnt` stays at 3; `clear` asserted in the COMPARE cycle → counters 0 and `res_valid` still pulses.
- `stim_valid` held high continuously → accepts spaced exactly SETTLE_CYC+2 cycles apart, and `op_*` are stable throughout SETTLE.
